binary_to_decimal_digits: RTL

BINARY_TO_DECIMAL_DIGITS -- requirements
Module: binary_to_decimal_digits

---
 rtl/binary_to_decimal_digits.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/binary_to_decimal_digits.sv
// Sequential binary-to-BCD converter (double dabble, one step per clock) that
// presents registered {dp, digit} pairs for a 7-segment display driver.
module binary_to_decimal_digits #(
    parameter int NUMBER_OF_DIGITS = 4,
    parameter int VALUE_WIDTH      = 14
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [VALUE_WIDTH-1:0]      in_value,
    input  logic [NUMBER_OF_DIGITS-1:0] in_dp_mask,
    output logic [4:0]                  digits [NUMBER_OF_DIGITS],
    output logic                        out_valid,
    output logic                        overflow
);

    localparam int BCD_W = 4 * NUMBER_OF_DIGITS;
    localparam int CNT_W = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;

    function automatic logic [63:0] max_display_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // One double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [63:0]      MAX_VALUE = max_display_value(NUMBER_OF_DIGITS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [VALUE_WIDTH-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]            bcd_q, bcd_d;
    logic [NUMBER_OF_DIGITS-1:0] dp_q, dp_d;
    logic                        ovf_pend_q, ovf_pend_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [4:0]                  digits_q [NUMBER_OF_DIGITS];
    logic [4:0]                  digits_d [NUMBER_OF_DIGITS];
    logic                        overflow_q, overflow_d;
    logic                        out_valid_q, out_valid_d;

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            dp_q        <= '0;
            ovf_pend_q  <= 1'b0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                digits_q[i] <= 5'd0;
            end
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            dp_q        <= dp_d;
            ovf_pend_q  <= ovf_pend_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                digits_q[i] <= digits_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = UPDATE;
                end else begin
                    state_d = CONVERT;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on transfer, shift during CONVERT, publish in UPDATE.
    always_comb begin
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        dp_d        = dp_q;
        ovf_pend_d  = ovf_pend_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            digits_d[i] = digits_q[i];
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d      = in_value;
                    bcd_d      = '0;
                    dp_d       = in_dp_mask;
                    ovf_pend_d = (64'(in_value) > MAX_VALUE);
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            CONVERT: begin
                // The truncating cast drops the bit leaving the top nibble (mod 10^N).
                bcd_d = BCD_W'({dabble_adjust(bcd_q), bin_q[VALUE_WIDTH-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            UPDATE: begin
                for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                    digits_d[i] = {dp_q[i], bcd_q[4*i +: 4]};
                end
                overflow_d  = ovf_pend_q;
                out_valid_d = 1'b1;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Handshake output decode.
    always_comb begin
        if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    assign digits    = digits_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule
